vend_credit_ctrl: RTL and testbench

Credit accumulator and change dispenser sitting directly downstream of the coin validator. Consumes each coin strobe together with the validator's legal/illegal verdict, keeps the customer's running credit, executes a purchase against a supplied item price, and returns the remaining credit as coins through a valid/ready handshake to the coin dispenser.

---
 rtl/vend_credit_ctrl.sv | 133 +++++++++++++
 tb/tb_vend_credit_ctrl.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/vend_credit_ctrl.sv
// vend_credit_ctrl
//   Credit accumulator and change dispenser behind the coin validator.
//   Accepts validated coins into a running credit and executes purchases
//   against item_price. It returns leftover credit as greedy 10/5/1 coins
//   over a valid/ready handshake.
// Ports:
//   clk, rst                : clock, async active-high reset
//   coin_strobe/value/ok    : coin from validator with legal verdict
//   select_strobe/item_price: purchase request
//   cancel                  : refund all credit
//   change_ready            : dispenser takes change_coin this cycle
//   credit                  : registered running credit
//   coin_accept/coin_reject : coin verdict pulses
//   vend_pulse/deny_pulse   : purchase outcome pulses
//   change_valid/change_coin: offered change coin
//   busy                    : not idle
module vend_credit_ctrl #(
   parameter int MAX_CREDIT = 50,
   parameter int CREDIT_W   = 7
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                coin_strobe,
   input  logic [3:0]          coin_value,
   input  logic                coin_ok,
   input  logic                select_strobe,
   input  logic [CREDIT_W-1:0] item_price,
   input  logic                cancel,
   input  logic                change_ready,
   output logic [CREDIT_W-1:0] credit,
   output logic                coin_accept,
   output logic                coin_reject,
   output logic                vend_pulse,
   output logic                deny_pulse,
   output logic                change_valid,
   output logic [3:0]          change_coin,
   output logic                busy
);

   typedef enum logic [1:0] {IDLE, VEND, CHANGE} state_t;

   localparam logic [CREDIT_W:0] MAX_SUM = (CREDIT_W+1)'(MAX_CREDIT);

   state_t              state, state_d;
   logic [CREDIT_W-1:0] credit_d;
   logic [CREDIT_W:0]   coin_sum;
   logic [CREDIT_W-1:0] coin_ext;
   logic                acc_d, rej_d, vend_d, deny_d;

   // Largest coin that still fits in the remaining credit.
   function automatic logic [3:0] greedy(input logic [CREDIT_W-1:0] c);
      if (c >= CREDIT_W'(10))     return 4'd10;
      else if (c >= CREDIT_W'(5)) return 4'd5;
      else                        return 4'd1;
   endfunction

   // One extra bit so an over-limit coin is compared, never wrapped.
   assign coin_sum = {1'b0, credit} + {{(CREDIT_W-3){1'b0}}, coin_value};
   assign coin_ext = {{(CREDIT_W-4){1'b0}}, change_coin};

   always_comb begin
      state_d  = state;
      credit_d = credit;
      acc_d    = 1'b0;
      rej_d    = 1'b0;
      vend_d   = 1'b0;
      deny_d   = 1'b0;
      case (state)
         IDLE: begin
            // A cancel with no credit is a no-op and lets lower-priority
            // requests through; any honoured or denied request bounces a coin.
            if (cancel && credit != '0) begin
               state_d = CHANGE;
               rej_d   = coin_strobe;
            end else if (select_strobe) begin
               rej_d = coin_strobe;
               if (item_price != '0 && credit >= item_price) begin
                  credit_d = credit - item_price;
                  state_d  = VEND;
                  vend_d   = 1'b1;
               end else begin
                  deny_d = 1'b1;
               end
            end else if (coin_strobe) begin
               if (coin_ok && coin_sum <= MAX_SUM) begin
                  credit_d = coin_sum[CREDIT_W-1:0];
                  acc_d    = 1'b1;
               end else begin
                  rej_d = 1'b1;
               end
            end
         end
         VEND: begin
            rej_d   = coin_strobe;
            state_d = (credit != '0) ? CHANGE : IDLE;
         end
         CHANGE: begin
            rej_d = coin_strobe;
            if (change_valid && change_ready) begin
               credit_d = credit - coin_ext;
               if (credit_d == '0) state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         credit       <= '0;
         coin_accept  <= 1'b0;
         coin_reject  <= 1'b0;
         vend_pulse   <= 1'b0;
         deny_pulse   <= 1'b0;
         change_valid <= 1'b0;
         change_coin  <= 4'd0;
         busy         <= 1'b0;
      end else begin
         state        <= state_d;
         credit       <= credit_d;
         coin_accept  <= acc_d;
         coin_reject  <= rej_d;
         vend_pulse   <= vend_d;
         deny_pulse   <= deny_d;
         // Offer follows next-state credit, so it holds while unacknowledged.
         change_valid <= (state_d == CHANGE);
         change_coin  <= (state_d == CHANGE) ? greedy(credit_d) : 4'd0;
         busy         <= (state_d != IDLE);
      end
   end

endmodule

// File: tb/tb_vend_credit_ctrl.sv
// Testbench for vend_credit_ctrl: directed scenarios plus random traffic,
// all checked against a transaction-level model (credit as an integer,
// pending change as a queue of coins).
module tb_vend_credit_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       coin_strobe = 1'b0;
   logic [3:0] coin_value = '0;
   logic       coin_ok = 1'b0;
   logic       select_strobe = 1'b0;
   logic [6:0] item_price = '0;
   logic       cancel = 1'b0;
   logic       change_ready = 1'b0;
   logic [6:0] credit;
   logic       coin_accept, coin_reject, vend_pulse, deny_pulse;
   logic       change_valid, busy;
   logic [3:0] change_coin;

   vend_credit_ctrl #(.MAX_CREDIT(50), .CREDIT_W(7)) dut (
      .clk(clk), .rst(rst),
      .coin_strobe(coin_strobe), .coin_value(coin_value), .coin_ok(coin_ok),
      .select_strobe(select_strobe), .item_price(item_price),
      .cancel(cancel), .change_ready(change_ready),
      .credit(credit), .coin_accept(coin_accept), .coin_reject(coin_reject),
      .vend_pulse(vend_pulse), .deny_pulse(deny_pulse),
      .change_valid(change_valid), .change_coin(change_coin), .busy(busy)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model state.
   int m_credit = 0;
   bit m_vend   = 0;
   int m_q[$];

   task automatic chk(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   // Break the whole credit into coins, largest first.
   function automatic void plan_change(input int c);
      m_q.delete();
      while (c >= 10) begin m_q.push_back(10); c -= 10; end
      while (c >= 5)  begin m_q.push_back(5);  c -= 5;  end
      while (c >= 1)  begin m_q.push_back(1);  c -= 1;  end
   endfunction

   function automatic bit m_busy();
      return m_vend || (m_q.size() > 0);
   endfunction

   task automatic cycle(input bit cs, input logic [3:0] cv, input bit cok,
                        input bit sel, input logic [6:0] pr, input bit can,
                        input bit rdy);
      bit e_acc = 0, e_rej = 0, e_vend = 0, e_deny = 0;
      @(negedge clk);
      coin_strobe = cs; coin_value = cv; coin_ok = cok;
      select_strobe = sel; item_price = pr; cancel = can; change_ready = rdy;
      if (m_vend) begin
         m_vend = 0;
         e_rej  = cs;
         if (m_credit > 0) plan_change(m_credit);
      end else if (m_q.size() > 0) begin
         e_rej = cs;
         if (rdy) m_credit -= m_q.pop_front();
      end else if (can && m_credit > 0) begin
         e_rej = cs;
         plan_change(m_credit);
      end else if (sel) begin
         e_rej = cs;
         if (pr != 0 && m_credit >= int'(pr)) begin
            m_credit -= int'(pr);
            m_vend = 1;
            e_vend = 1;
         end else e_deny = 1;
      end else if (cs) begin
         if (cok && m_credit + int'(cv) <= 50) begin
            m_credit += int'(cv);
            e_acc = 1;
         end else e_rej = 1;
      end
      @(posedge clk);
      #1;
      chk("credit",       int'(credit),       m_credit);
      chk("coin_accept",  int'(coin_accept),  int'(e_acc));
      chk("coin_reject",  int'(coin_reject),  int'(e_rej));
      chk("vend_pulse",   int'(vend_pulse),   int'(e_vend));
      chk("deny_pulse",   int'(deny_pulse),   int'(e_deny));
      chk("change_valid", int'(change_valid), int'(m_q.size() > 0));
      chk("change_coin",  int'(change_coin),  (m_q.size() > 0) ? m_q[0] : 0);
      chk("busy",         int'(busy),         int'(m_busy()));
   endtask

   task automatic coin(input int v, input bit ok);
      cycle(1, 4'(v), ok, 0, '0, 0, 1);
   endtask

   task automatic drain();
      for (int i = 0; i < 64 && m_busy(); i++) cycle(0, '0, 0, 0, '0, 0, 1);
      chk("drain_done", int'(busy), 0);
   endtask

   task automatic refund();
      cycle(0, '0, 0, 0, '0, 1, 1);
      drain();
   endtask

   // Reset asserted between edges; outputs must clear without a clock.
   task automatic do_reset();
      @(negedge clk);
      #2;
      rst = 1'b1;
      coin_strobe = 0; select_strobe = 0; cancel = 0; change_ready = 0;
      #1;
      chk("rst_credit", int'(credit), 0);
      chk("rst_pulses", int'({coin_accept, coin_reject, vend_pulse, deny_pulse}), 0);
      chk("rst_change", int'({change_valid, change_coin}), 0);
      chk("rst_busy",   int'(busy), 0);
      m_credit = 0; m_vend = 0; m_q.delete();
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      int v;
      do_reset();

      // Coin acceptance and an illegal coin.
      coin(10, 1); coin(5, 1); coin(1, 1); coin(3, 0);
      refund();

      // Upper credit limit.
      repeat (4) coin(10, 1);
      coin(5, 1); coin(10, 1); coin(5, 1);
      chk("at_max", int'(credit), 50);
      refund();

      // Purchase with change, then a denied purchase.
      coin(10, 1); coin(5, 1); coin(1, 1);
      cycle(0, '0, 0, 1, 7'd9, 0, 1);
      drain();
      coin(10, 1); coin(5, 1); coin(1, 1);
      cycle(0, '0, 0, 1, 7'd20, 0, 1);
      cycle(0, '0, 0, 1, 7'd0, 0, 1);
      refund();

      // Refund under dispenser backpressure.
      coin(10, 1); coin(10, 1); coin(5, 1); coin(1, 1); coin(1, 1);
      cycle(0, '0, 0, 0, '0, 1, 0);
      repeat (3) cycle(0, '0, 0, 0, '0, 0, 0);
      drain();

      // Coin colliding with a select, and coins during change.
      coin(10, 1);
      cycle(1, 4'd10, 1, 1, 7'd5, 0, 1);
      cycle(1, 4'd5, 1, 0, '0, 0, 1);
      cycle(1, 4'd1, 1, 1, 7'd1, 1, 0);
      drain();
      cycle(0, '0, 0, 0, '0, 1, 1);   // cancel at zero credit is a no-op

      // Mid-operation reset drops credit and change.
      coin(10, 1); coin(10, 1);
      cycle(0, '0, 0, 0, '0, 1, 0);
      do_reset();

      // Random traffic.
      for (int n = 0; n < 1500; n++) begin
         if ($urandom_range(199) == 0) do_reset();
         case ($urandom_range(3))
            0: v = 1;
            1: v = 5;
            2: v = 10;
            default: v = $urandom_range(15);
         endcase
         cycle($urandom_range(2) == 0, 4'(v), $urandom_range(4) != 0,
               $urandom_range(7) == 0, 7'($urandom_range(40)),
               $urandom_range(19) == 0, $urandom_range(9) < 7);
      end
      drain();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
